serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
//   Each step is one full-subtractor cell with a registered borrow fed back to the next bit.
//   Trades WIDTH+1 cycles of latency for a single cell and flop chain in area-tight datapaths.
//   Sits downstream of an operand source using a start/busy/done handshake; results hold until next start.
// PARAMETERS
//   WIDTH   8   operand and result width in bits (>= 2)
// PORTS
//   clk     in   1      single clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   bin     in   1      borrow-in, captured on accepted start
//   busy    out  1      high while operation in progress (SHIFT or DONE)
//   done    out  1      one-cycle pulse: diff/bout valid
//   diff    out  WIDTH  difference, registered
//   bout    out  1      borrow-out from MSB (1 = unsigned a < b+bin)
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; busy=0, done=0, diff=0, bout=0, count=0, borrow reg=0 (ovf=0 if enabled).
//   - FSM: IDLE -> SHIFT on start; SHIFT -> DONE after WIDTH bit-steps; DONE -> IDLE unconditionally.
//   - IDLE: start=1 at edge T0 loads a, b into shift regs, bin into borrow reg, count=0; busy=1 from T0+.
//   - SHIFT step k (k=0..WIDTH-1): x=a_sr[0], y=b_sr[0], c=borrow reg;
//       d = x^y^c; brw = (~x&y)|(~x&c)|(y&c); d shifts into diff_sr MSB; borrow reg<=brw; operand regs shift right.
//   - After step WIDTH-1, go DONE: diff<=diff_sr, bout<=final borrow; done=1 for exactly that one cycle.
//   - Latency: done high in cycle T0+WIDTH+1 (WIDTH=8 -> 9th edge after start); busy low on next cycle.
//   - Throughput: next start accepted earliest the cycle after done (IDLE); back-to-back = WIDTH+2 cycles/op.
//   - start while busy (SHIFT or DONE): ignored, no effect on in-flight operation or inputs captured.
//   - a/b/bin changing after the start edge: no effect (captured at start).
//   - diff/bout hold last result through IDLE and the next operation until its DONE; not updated per bit.
//   - Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
//   - Arithmetic: modulo 2^WIDTH; diff == (a - b - bin) mod 2^WIDTH; bout == ({1'b0,a} < {1'b0,b} + bin).
//   - count width = $clog2(WIDTH)+1; no wrap within an operation.
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined: extra output port ovf (out, 1), signed two's-complement overflow,
//     ovf = (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB]) using captured operands; updated with diff at DONE,
//     held otherwise, reset 0.
//   SERIAL_SUB_OVF_EN undefined: no ovf port, no MSB capture logic; all other behaviour identical.
// TESTING (WIDTH=8)
//   1. a=100, b=58, bin=0, start 1 cycle -> done on 9th edge, diff=8'h2A (42), bout=0; busy high 9 cycles.
//   2. a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1; a=8'h05, b=8'h05, bin=1 -> diff=8'hFF, bout=1.
//   3. a=8'hFF, b=8'h00, bin=0 -> diff=8'hFF, bout=0; diff/bout unchanged for 20 idle cycles after.
//   4. Start a=9,b=3; pulse start with a=50,b=1 at cycles 3 and 9 -> one done, diff=6; no second op.
//   5. Start a=200,b=100; assert rst at cycle 4 -> busy=done=diff=bout=0 same cycle; no done pulse;
//      new start after release yields correct result.
//   6. SERIAL_SUB_OVF_EN: a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1, bout=0; a=8'h10, b=8'h01 -> ovf=0.
//   Random: 1000 ops vs. reference model, with random start gaps incl. back-to-back.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor step per clock.
// A start in IDLE captures the operands; WIDTH shift steps follow, then a one-cycle DONE
// state presents diff/bout, which then hold until the next operation completes.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] diff_sr;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             x;
    logic             y;
    logic             d;
    logic             brw;
    logic [WIDTH-1:0] shifted;
    logic             last_step;

    // Single full-subtractor cell on the current LSBs, plus the result word as it would look after this step
    always_comb begin
        x         = a_sr[0];
        y         = b_sr[0];
        d         = x ^ y ^ borrow;
        brw       = (~x & y) | (~x & borrow) | (y & borrow);
        shifted   = {d, diff_sr};
        last_step = (state == SHIFT) && (count == LAST);
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; busy and done come straight from the registered state so they are glitch-free
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting, and the final result update on the last step only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            borrow  <= 1'b0;
            count   <= '0;
            diff    <= '0;
            bout    <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            count  <= '0;
        end else if (state == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            diff_sr <= shifted[WIDTH-1:1];
            borrow  <= brw;
            count   <= count + CW'(1);
            if (last_step) begin
                diff <= shifted;
                bout <= brw;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // On the last step x and y are the captured operand MSBs, so overflow needs no extra storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (last_step) begin
            ovf <= (x ^ y) & (d ^ x);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table vectors, hand-written corner sequences and randomized operations
// for serial_subtractor (WIDTH=8), checked against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int         nChecks = 0;
    int         nFails  = 0;
    logic [7:0] prevDiff;
    logic       prevBout;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[11];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] refDiff(input logic [7:0] ra, input logic [7:0] rb, input logic rbin);
        int r;
        r = int'(ra) - int'(rb) - int'(rbin);
        return 8'(r);
    endfunction

    function automatic logic refBout(input logic [7:0] ra, input logic [7:0] rb, input logic rbin);
        return (int'(ra) < int'(rb) + int'(rbin));
    endfunction

    function automatic logic refOvf(input logic [7:0] ra, input logic [7:0] rb, input logic rbin);
        int r;
        r = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
        return (r < -128) || (r > 127);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Starts one operation once the DUT is idle and returns the number of edges until done
    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                                 input bit noise, output int lat);
        int guard;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        while (!done && lat < 20) begin
            if (lat == 4) begin
                checkOutput("hold_diff", 32'(diff), 32'(prevDiff));
                checkOutput("hold_bout", 32'(bout), 32'(prevBout));
            end
            if (noise) begin
                start = 1'($urandom);
                a     = 8'($urandom);
                b     = 8'($urandom);
                bin   = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic runAndCheck(input string name, input logic [7:0] ia, input logic [7:0] ib,
                               input logic ibin, input logic [7:0] expDiff, input logic expBout,
                               input bit noise);
        int lat;
        applyStimulus(ia, ib, ibin, noise, lat);
        checkOutput({name, "_latency"}, 32'(lat), 32'd9);
        checkOutput({name, "_diff"}, 32'(diff), 32'(expDiff));
        checkOutput({name, "_bout"}, 32'(bout), 32'(expBout));
`ifdef SERIAL_SUB_OVF_EN
        checkOutput({name, "_ovf"}, 32'(ovf), 32'(refOvf(ia, ib, ibin)));
`endif
        prevDiff = expDiff;
        prevBout = expBout;
    endtask

    initial begin
        int         busyCnt;
        int         doneCnt;
        int         doneEdge;
        logic [7:0] diffAtDone;
        logic       boutAtDone;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        int         gap;

        vecs[0]  = '{8'd100, 8'd58, 1'b0, 8'h2A, 1'b0};
        vecs[1]  = '{8'h00,  8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2]  = '{8'h05,  8'h05, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{8'hFF,  8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[4]  = '{8'h00,  8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[5]  = '{8'hFF,  8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{8'h80,  8'h01, 1'b0, 8'h7F, 1'b0};
        vecs[7]  = '{8'h10,  8'h01, 1'b0, 8'h0F, 1'b0};
        vecs[8]  = '{8'h00,  8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{8'hFF,  8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[10] = '{8'h01,  8'h00, 1'b1, 8'h00, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_diff", 32'(diff), 32'd0);
        checkOutput("reset_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
        rst      = 1'b0;
        prevDiff = '0;
        prevBout = 1'b0;
        @(negedge clk);

        $display("[TB] latency and busy window");
        a        = 8'd100;
        b        = 8'd58;
        bin      = 1'b0;
        start    = 1'b1;
        busyCnt  = 0;
        doneCnt  = 0;
        doneEdge = 0;
        diffAtDone = '0;
        boutAtDone = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                doneEdge   = e;
                diffAtDone = diff;
                boutAtDone = bout;
            end
        end
        checkOutput("t1_done_edge", 32'(doneEdge), 32'd9);
        checkOutput("t1_done_count", 32'(doneCnt), 32'd1);
        checkOutput("t1_busy_cycles", 32'(busyCnt), 32'd9);
        checkOutput("t1_diff", 32'(diffAtDone), 32'h2A);
        checkOutput("t1_bout", 32'(boutAtDone), 32'd0);
        prevDiff = 8'h2A;
        prevBout = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 11; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                        vecs[i].diff, vecs[i].bout, 1'b0);
        end

        $display("[TB] result hold through idle");
        runAndCheck("hold", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
            checkOutput("idle_diff", 32'(diff), 32'hFF);
            checkOutput("idle_bout", 32'(bout), 32'd0);
        end
        checkOutput("idle_no_done", 32'(doneCnt), 32'd0);

        $display("[TB] start while busy ignored");
        doneCnt    = 0;
        diffAtDone = '0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 1) begin
                a     = 8'd9;
                b     = 8'd3;
                bin   = 1'b0;
                start = 1'b1;
            end else if (e == 3 || e == 9 || e == 10) begin
                a     = 8'd50;
                b     = 8'd1;
                bin   = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                doneCnt++;
                diffAtDone = diff;
            end
        end
        start = 1'b0;
        checkOutput("t4_done_count", 32'(doneCnt), 32'd1);
        checkOutput("t4_diff", 32'(diffAtDone), 32'd6);
        checkOutput("t4_bout", 32'(bout), 32'd0);
        checkOutput("t4_busy_end", 32'(busy), 32'd0);
        prevDiff = 8'd6;
        prevBout = 1'b0;

        $display("[TB] reset mid-operation");
        a     = 8'd200;
        b     = 8'd100;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_done", 32'(done), 32'd0);
        checkOutput("t5_diff", 32'(diff), 32'd0);
        checkOutput("t5_bout", 32'(bout), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) doneCnt++;
        end
        checkOutput("t5_no_done", 32'(doneCnt), 32'd0);
        checkOutput("t5_busy_idle", 32'(busy), 32'd0);
        prevDiff = '0;
        prevBout = 1'b0;
        runAndCheck("t5_after", 8'd200, 8'd100, 1'b0, 8'd100, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        $display("[TB] signed overflow");
        runAndCheck("ovf_a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0);
        checkOutput("ovf_a_set", 32'(ovf), 32'd1);
        runAndCheck("ovf_b", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        checkOutput("ovf_b_clear", 32'(ovf), 32'd0);
`endif

        $display("[TB] randomized operations");
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 7))
                0:       ra = 8'h00;
                1:       ra = 8'hFF;
                2:       ra = 8'h80;
                3:       ra = 8'h7F;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       rb = 8'h80;
                3:       rb = 8'h01;
                default: rb = 8'($urandom);
            endcase
            rbin = 1'($urandom);
            runAndCheck($sformatf("rand%0d", i), ra, rb, rbin, refDiff(ra, rb, rbin),
                        refBout(ra, rb, rbin), 1'($urandom));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
